// File: rtl/float_to_int.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int
// Description : Sequential half-precision float to signed integer decoder.
//               The magnitude is aligned by a one-bit-per-cycle shift FSM
//               behind valid/ready handshakes. Default rounding is truncation
//               toward zero. Defining FLOAT_TO_INT_ROUND_NEAREST_EN selects
//               round-to-nearest, ties-to-even, on right shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_int #(
  parameter int FLOAT_WIDTH = 16,
  parameter int EXP_WIDTH   = 5,
  parameter int MAN_WIDTH   = 10,
  parameter int INT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_WIDTH-1:0] float_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] int_out,
  output logic                 overflow,
  output logic                 inexact
);

  localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
  // Counter is wide enough for any legal shift distance.
  localparam int KW   = $clog2(INT_WIDTH) + 1;

  localparam logic [INT_WIDTH-1:0] SAT_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] SAT_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Field split of the incoming float.
  logic                 sign_in;
  logic [EXP_WIDTH-1:0] exp_in;
  logic [MAN_WIDTH-1:0] man_in;
  logic signed [31:0]   unb;

  assign sign_in = float_in[FLOAT_WIDTH-1];
  assign exp_in  = float_in[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign man_in  = float_in[MAN_WIDTH-1:0];
  assign unb     = $signed({{(32-EXP_WIDTH){1'b0}}, exp_in}) - BIAS;

  // Working registers for one conversion.
  logic                 sign;
  logic [INT_WIDTH-1:0] acc;
  logic [KW-1:0]        k;
  logic                 left;
  logic                 sat;
  logic                 sticky;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  logic                 guard;
  logic                 load_guard;
`endif

  // Values loaded on the accepting edge.
  logic [INT_WIDTH-1:0] load_acc;
  logic [KW-1:0]        load_k;
  logic                 load_left;
  logic                 load_sat;
  logic                 load_sticky;

  // FINISH-stage results.
  logic [INT_WIDTH-1:0] mag;
  logic [INT_WIDTH-1:0] result;
  logic                 inexact_nxt;

  assign in_ready = (state == IDLE);

  // Classify the input and pick initial accumulator, shift count and direction.
  always_comb begin
    load_acc    = '0;
    load_k      = '0;
    load_left   = 1'b0;
    load_sat    = 1'b0;
    load_sticky = 1'b0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    load_guard  = 1'b0;
`endif
    if (exp_in == '0) begin
      // Zero (subnormals flushed): nothing to do.
    end else if (exp_in == '1 || unb >= INT_WIDTH - 1) begin
      load_sat = 1'b1;
    end else if (unb < 0) begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      // |x| in [0.5,1): hidden one is the guard bit; smaller values are pure sticky.
      if (unb == -1) begin
        load_guard  = 1'b1;
        load_sticky = |man_in;
      end else begin
        load_sticky = 1'b1;
      end
`else
      load_sticky = 1'b1;
`endif
    end else begin
      load_acc = {{(INT_WIDTH-MAN_WIDTH-1){1'b0}}, 1'b1, man_in};
      if (unb >= MAN_WIDTH) begin
        load_left = 1'b1;
        load_k    = KW'(unb - MAN_WIDTH);
      end else begin
        load_k    = KW'(MAN_WIDTH - unb);
      end
    end
  end

  // Rounding (optional), sign application and saturation select.
  always_comb begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    mag         = acc + {{(INT_WIDTH-1){1'b0}}, guard & (sticky | acc[0])};
    inexact_nxt = guard | sticky;
`else
    mag         = acc;
    inexact_nxt = sticky;
`endif
    if (sat)
      result = sign ? SAT_NEG : SAT_POS;
    else
      result = sign ? (~mag + 1'b1) : mag;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (load_k != '0) ? SHIFT : FINISH;
      SHIFT:   if (k == KW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load, shift one bit per cycle, register result, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      acc       <= '0;
      k         <= '0;
      left      <= 1'b0;
      sat       <= 1'b0;
      sticky    <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      guard     <= 1'b0;
`endif
      int_out   <= '0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign   <= sign_in;
            acc    <= load_acc;
            k      <= load_k;
            left   <= load_left;
            sat    <= load_sat;
            sticky <= load_sticky;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard  <= load_guard;
`endif
          end
        end
        SHIFT: begin
          if (left) begin
            acc <= acc << 1;
          end else begin
            acc <= acc >> 1;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard  <= acc[0];
            sticky <= sticky | guard;
`else
            sticky <= sticky | acc[0];
`endif
          end
          k <= k - KW'(1);
        end
        FINISH: begin
          int_out   <= result;
          overflow  <= sat;
          inexact   <= inexact_nxt;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_to_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_to_int
// Description : Directed self-checking bench for float_to_int. Expected
//               rounding results follow FLOAT_TO_INT_ROUND_NEAREST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] float_in = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] int_out;
  logic        overflow;
  logic        inexact;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] f;
    logic [31:0] r;
    logic        ov;
    logic        inx;
    int          lat;
  } vec_t;

  float_to_int dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_in  (float_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Drive one input, count edges (accepting edge = 1) until out_valid, then take it.
  task automatic run_op(input logic [15:0] f, output logic [31:0] res, output logic ov,
                        output logic inx, output int lat, output bit to);
    to  = 1'b0;
    @(negedge clk);
    float_in = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    float_in = 16'h0000;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
    res = int_out;
    ov  = overflow;
    inx = inexact;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #6;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || int_out !== 32'h0 ||
        overflow !== 1'b0 || inexact !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b vld=%b out=%h ov=%b inx=%b (need 1 0 00000000 0 0)",
               in_ready, out_valid, int_out, overflow, inexact);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_conversions();
    vec_t v [13];
    logic [31:0] res;
    logic ov, inx;
    int lat;
    bit to;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    v[3]  = '{16'h3E00, 32'h00000002, 1'b0, 1'b1, 12};
    v[5]  = '{16'h4300, 32'h00000004, 1'b0, 1'b1, 11};
    v[12] = '{16'hBE00, 32'hFFFFFFFE, 1'b0, 1'b1, 12};
`else
    v[3]  = '{16'h3E00, 32'h00000001, 1'b0, 1'b1, 12};
    v[5]  = '{16'h4300, 32'h00000003, 1'b0, 1'b1, 11};
    v[12] = '{16'hBE00, 32'hFFFFFFFF, 1'b0, 1'b1, 12};
`endif
    v[0]  = '{16'h3C00, 32'h00000001, 1'b0, 1'b0, 12};
    v[1]  = '{16'hC500, 32'hFFFFFFFB, 1'b0, 1'b0, 10};
    v[2]  = '{16'h7BFF, 32'h0000FFE0, 1'b0, 1'b0, 7};
    v[4]  = '{16'h3800, 32'h00000000, 1'b0, 1'b1, 2};
    v[6]  = '{16'h4100, 32'h00000002, 1'b0, 1'b1, 11};
    v[7]  = '{16'h7C00, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    v[8]  = '{16'hFC00, 32'h80000000, 1'b1, 1'b0, 2};
    v[9]  = '{16'h0000, 32'h00000000, 1'b0, 1'b0, 2};
    v[10] = '{16'h8000, 32'h00000000, 1'b0, 1'b0, 2};
    v[11] = '{16'h6400, 32'h00000400, 1'b0, 1'b0, 2};
    for (int i = 0; i < 13; i++) begin
      run_op(v[i].f, res, ov, inx, lat, to);
      tests++;
      if (to) begin
        fails++;
        $display("FAIL conv_%h_timeout: out_valid never rose within %0d edges", v[i].f, lat);
      end
      tests++;
      if (res !== v[i].r || ov !== v[i].ov || inx !== v[i].inx) begin
        fails++;
        $display("FAIL conv_%h_value: got %h ov=%b inx=%b, need %h ov=%b inx=%b",
                 v[i].f, res, ov, inx, v[i].r, v[i].ov, v[i].inx);
      end
      tests++;
      if (lat !== v[i].lat) begin
        fails++;
        $display("FAIL conv_%h_latency: got %0d edges, need %0d", v[i].f, lat, v[i].lat);
      end
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL conv_%h_release: vld=%b rdy=%b, need 0 1", v[i].f, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    float_in = 16'hC500;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL bp_timeout: out_valid never rose within %0d edges", n);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      float_in = 16'h3C00;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int_out !== 32'hFFFFFFFB ||
          overflow !== 1'b0 || inexact !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b out=%h ov=%b inx=%b, need 1 0 fffffffb 0 0",
                 i, out_valid, in_ready, int_out, overflow, inexact);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    float_in  = 16'h0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: vld=%b rdy=%b, need 0 1", out_valid, in_ready);
    end
    repeat (15) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_no_ghost: vld=%b rdy=%b, need 0 1 (ignored pulses accepted)",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    logic ov, inx;
    int lat;
    bit to;
    @(negedge clk);
    float_in = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_in_ready: got %b, need 0 while shifting", in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || int_out !== 32'h0 ||
        overflow !== 1'b0 || inexact !== 1'b0) begin
      fails++;
      $display("FAIL midreset_values: rdy=%b vld=%b out=%h ov=%b inx=%b (need 1 0 00000000 0 0)",
               in_ready, out_valid, int_out, overflow, inexact);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_aborted: out_valid=%b, need 0", out_valid);
    end
    run_op(16'h4000, res, ov, inx, lat, to);
    tests++;
    if (to || res !== 32'h2 || ov !== 1'b0 || inx !== 1'b0 || lat !== 11) begin
      fails++;
      $display("FAIL midreset_recover: to=%b got %h ov=%b inx=%b lat=%0d, need 00000002 0 0 11",
               to, res, ov, inx, lat);
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_backpressure();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
